hub75_rx_capture: RTL

// Receive side of the HUB75 panel interface; the same bus our display driver transmits.
// - Oversamples HUB75 CLK/STB/OE/A-D/RGB on clk and rebuilds each latched line from the

---
 rtl/hub75_rx_capture_if.sv | 20 ++
 rtl/hub75_rx_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_rx_capture_if.sv
// Pixel-write stream from the HUB75 capture block to a reconstruction framebuffer.
interface hub75_rx_capture_if #(
    parameter int unsigned hpixel_p   = 64,
    parameter int unsigned bpp_p      = 8,
    parameter int unsigned segments_p = 2
);
    localparam int unsigned AddrW = $clog2(16 * hpixel_p);
    localparam int unsigned BitW  = $clog2(bpp_p);

    logic                             wr_valid;
    logic                             wr_ready;
    logic [AddrW-1:0]                 wr_addr;
    logic [BitW-1:0]                  wr_bit;
    logic [segments_p-1:0][2:0]       wr_data;

    modport master (output wr_valid, output wr_addr, output wr_bit, output wr_data,
                    input  wr_ready);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_bit, input  wr_data,
                    output wr_ready);
endinterface

// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: oversamples the panel bus, rebuilds latched lines, tracks the bit-plane,
// streams per-pixel writes and measures OE on-time.
module hub75_rx_capture #(
    parameter int unsigned hpixel_p      = 64,
    parameter int unsigned bpp_p         = 8,
    parameter int unsigned segments_p    = 2,
    parameter int unsigned sync_stages_p = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic                  i_clear_err,
    input  logic                  i_hub_clk,
    input  logic                  i_stb,
    input  logic                  i_oe,
    input  logic                  i_a,
    input  logic                  i_b,
    input  logic                  i_c,
    input  logic                  i_d,
    input  logic [segments_p-1:0] i_r,
    input  logic [segments_p-1:0] i_g,
    input  logic [segments_p-1:0] i_b_c,
    hub75_rx_capture_if.master    wr,
    output logic [15:0]           o_oe_cycles,
    output logic                  o_oe_valid,
    output logic                  o_overflow,
    output logic                  o_col_err
);
    localparam int unsigned AddrW = $clog2(16 * hpixel_p);
    localparam int unsigned BitW  = $clog2(bpp_p);
    localparam int unsigned BeatW = $clog2(hpixel_p);
    localparam int unsigned ColW  = $clog2(hpixel_p + 1);
    localparam int unsigned InW   = 3 * segments_p + 7;

    typedef logic [segments_p-1:0][2:0] pix_t;
    typedef enum logic {IDLE, DRAIN} state_e;

    // Input synchronizer; every pin sees the same delay so data stays aligned with strobes
    logic [InW-1:0]                    in_raw;
    logic [InW-1:0]                    in_s;
    logic [sync_stages_p-1:0][InW-1:0] sync_q;
    logic [2:0]                        prev_q;
    logic                              hclk_s, stb_s, oe_s;
    logic [3:0]                        row_s;
    pix_t                              pix_s;

    assign in_raw = {i_hub_clk, i_stb, i_oe, i_a, i_b, i_c, i_d, i_b_c, i_g, i_r};
    assign in_s   = sync_q[sync_stages_p-1];
    assign hclk_s = in_s[3*segments_p+6];
    assign stb_s  = in_s[3*segments_p+5];
    assign oe_s   = in_s[3*segments_p+4];
    assign row_s  = in_s[3*segments_p+3 -: 4];

    always_comb begin
        pix_s = '0;
        for (int s = 0; s < int'(segments_p); s++) begin
            pix_s[s] = {in_s[2*segments_p+s], in_s[segments_p+s], in_s[s]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_raw;
            for (int i = 1; i < int'(sync_stages_p); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= {oe_s, stb_s, hclk_s};
        end
    end

    logic shift_ev, latch_ev, oe_fall;
    assign shift_ev = i_enable & hclk_s & ~prev_q[0];
    assign latch_ev = i_enable & stb_s  & ~prev_q[1];
    assign oe_fall  = ~oe_s & prev_q[2];

    // Shift register with the current bit already applied, so a coincident latch includes it
    logic [hpixel_p-1:0][segments_p-1:0][2:0] sr_q, sr_shift, line_q;
    logic [ColW-1:0]                          col_q, col_shift;

    always_comb begin
        sr_shift  = sr_q;
        col_shift = col_q;
        if (shift_ev && (col_q < ColW'(hpixel_p))) begin
            sr_shift[col_q[BeatW-1:0]] = pix_s;
            col_shift                  = col_q + ColW'(1);
        end
    end

    state_e           state_q;
    logic [BeatW-1:0] beat_q;
    logic [3:0]       row_q;
    logic [BitW-1:0]  plane_q, plane_new;
    logic             plane_vld_q;
    logic             last_beat, accept;
    logic [AddrW-1:0] base_new;

    always_comb begin
        plane_new = '0;
        if (plane_vld_q && (row_s == row_q)) begin
            plane_new = (plane_q == BitW'(bpp_p - 1)) ? '0 : plane_q + BitW'(1);
        end
    end

    assign last_beat = (state_q == DRAIN) && wr.wr_ready && (beat_q == BeatW'(hpixel_p - 1));
    assign accept    = latch_ev && ((state_q == IDLE) || last_beat);
    assign base_new  = AddrW'(32'(row_s) * 32'(hpixel_p));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            sr_q        <= '0;
            line_q      <= '0;
            row_q       <= '0;
            plane_q     <= '0;
            plane_vld_q <= 1'b0;
        end else if (!i_enable) begin
            col_q       <= '0;
            sr_q        <= '0;
            plane_vld_q <= 1'b0;
        end else if (latch_ev) begin
            col_q <= '0;
            sr_q  <= '0;
            if (accept) begin
                line_q      <= sr_shift;
                row_q       <= row_s;
                plane_q     <= plane_new;
                plane_vld_q <= 1'b1;
            end
        end else begin
            col_q <= col_shift;
            sr_q  <= sr_shift;
        end
    end

    // Drain FSM; stream outputs are loaded one beat ahead and held while stalled
    logic             wr_valid_q;
    logic [AddrW-1:0] wr_addr_q;
    logic [BitW-1:0]  wr_bit_q;
    pix_t             wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_bit_q   <= '0;
            wr_data_q  <= '0;
        end else if (accept) begin
            state_q    <= DRAIN;
            beat_q     <= '0;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= base_new;
            wr_bit_q   <= plane_new;
            wr_data_q  <= sr_shift[0];
        end else if ((state_q == DRAIN) && wr.wr_ready) begin
            if (beat_q == BeatW'(hpixel_p - 1)) begin
                state_q    <= IDLE;
                wr_valid_q <= 1'b0;
            end else begin
                beat_q    <= beat_q + BeatW'(1);
                wr_addr_q <= wr_addr_q + AddrW'(1);
                wr_data_q <= line_q[beat_q + BeatW'(1)];
            end
        end
    end

    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_bit   = wr_bit_q;
    assign wr.wr_data  = wr_data_q;

    // OE on-time counter, independent of capture enable
    logic [15:0] oe_cnt_q, oe_cycles_q;
    logic        oe_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_cnt_q    <= '0;
            oe_cycles_q <= '0;
            oe_valid_q  <= 1'b0;
        end else if (oe_fall) begin
            oe_cycles_q <= oe_cnt_q;
            oe_valid_q  <= 1'b1;
            oe_cnt_q    <= '0;
        end else begin
            oe_valid_q <= 1'b0;
            if (oe_s && (oe_cnt_q != 16'hFFFF)) begin
                oe_cnt_q <= oe_cnt_q + 16'd1;
            end
        end
    end

    assign o_oe_cycles = oe_cycles_q;
    assign o_oe_valid  = oe_valid_q;

    // Sticky error flags; a new event in the clear cycle keeps the flag set
    logic overflow_q, col_err_q;
    logic ovf_set, col_set;

    assign ovf_set = latch_ev && !accept;
    assign col_set = latch_ev && (col_shift != ColW'(hpixel_p));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            col_err_q  <= 1'b0;
        end else begin
            if (ovf_set)          overflow_q <= 1'b1;
            else if (i_clear_err) overflow_q <= 1'b0;
            if (col_set)          col_err_q  <= 1'b1;
            else if (i_clear_err) col_err_q  <= 1'b0;
        end
    end

    assign o_overflow = overflow_q;
    assign o_col_err  = col_err_q;
endmodule
